// File: rtl/act_sched_pkg.sv
// Shared definitions for the ReLU activation-unit scheduler: state encoding,
// source-select codes and cfgdat field layout.
package act_sched_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CAPT  = 2'd1,
      TURN  = 2'd2,
      DRIVE = 2'd3
   } state_t;

   localparam logic [1:0] SEL_NONE = 2'b00;
   localparam logic [1:0] SEL_ACT1 = 2'b10;
   localparam logic [1:0] SEL_ACT2 = 2'b11;

   localparam int CFG_SEL_LSB = 0;
   localparam int CFG_OE_LSB  = 2;

   function automatic logic [1:0] sel_code(input logic s);
      return s ? SEL_ACT2 : SEL_ACT1;
   endfunction

   function automatic logic [1:0] grant_vec(input logic w);
      return w ? 2'b10 : 2'b01;
   endfunction

   function automatic logic [3:0] cfg_word(input logic [1:0] sel, input logic [1:0] oe);
      logic [3:0] c;
      c = '0;
      c[CFG_SEL_LSB +: 2] = sel;
      c[CFG_OE_LSB +: 2]  = oe;
      return c;
   endfunction

endpackage

// File: rtl/act_sched_rr.sv
// Two-way round-robin arbiter; the priority pointer p lives in the parent.
module act_sched_rr
   import act_sched_pkg::*;
(
   input  logic [1:0] req,
   input  logic       p,
   output logic [1:0] win
);

   always_comb begin
      win = 2'b00;
      if (req == 2'b11) win = grant_vec(p);
      else              win = req;
   end

endmodule

// File: rtl/act_sched.sv
// act_sched: arbitrates two requesters onto the shared ReLU unit (capture, turnaround, drive).
// Build option ACT_SCHED_TURN_EN inserts the bus-turnaround cycle between capture and drive.
module act_sched
   import act_sched_pkg::*;
#(
   parameter int HOLD = 1,
   parameter int CW   = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic [1:0] src,
   input  logic [3:0] dst,
   output logic [1:0] gnt,
   output logic [1:0] done,
   output logic       busy,
   output logic [3:0] cfgdat,
   output logic       rtm_en
);

   localparam logic [CW-1:0] CNT_LOAD      = CW'(HOLD - 1);
   localparam logic          LAST_ON_ENTRY = (HOLD == 1);

   state_t        state;
   logic          p;
   logic          w;
   logic [1:0]    win;
   logic [1:0]    dst_w;
   logic [1:0]    dst_q;
   logic [CW-1:0] cnt;

   act_sched_rr u_rr (
      .req (req),
      .p   (p),
      .win (win)
   );

   assign dst_w = w ? dst[3:2] : dst[1:0];

`ifndef ACT_SCHED_TURN_EN
   logic [1:0] dst_win;
   assign dst_win = win[1] ? dst[3:2] : dst[1:0];
`endif

   // Outputs are computed for the state being entered, so every one is a flop.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= IDLE;
         p      <= 1'b0;
         w      <= 1'b0;
         dst_q  <= 2'b00;
         cnt    <= '0;
         gnt    <= 2'b00;
         done   <= 2'b00;
         busy   <= 1'b0;
         cfgdat <= 4'b0000;
         rtm_en <= 1'b0;
      end else begin
         gnt    <= 2'b00;
         done   <= 2'b00;
         cfgdat <= 4'b0000;
         rtm_en <= 1'b0;
         case (state)
            IDLE: begin
               busy <= 1'b0;
               if (|req) begin
                  state  <= CAPT;
                  w      <= win[1];
                  p      <= ~win[1];
                  gnt    <= win;
                  busy   <= 1'b1;
                  cfgdat <= cfg_word(sel_code(src[win[1]]), 2'b00);
                  rtm_en <= 1'b1;
`ifndef ACT_SCHED_TURN_EN
                  if (dst_win == 2'b00) done <= win;
`endif
               end
            end
            CAPT: begin
               dst_q <= dst_w;
`ifdef ACT_SCHED_TURN_EN
               state <= TURN;
               if (dst_w == 2'b00) done <= grant_vec(w);
`else
               if (dst_w == 2'b00) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else begin
                  state  <= DRIVE;
                  cnt    <= CNT_LOAD;
                  cfgdat <= cfg_word(SEL_NONE, dst_w);
                  if (LAST_ON_ENTRY) done <= grant_vec(w);
               end
`endif
            end
            TURN: begin
               if (dst_q == 2'b00) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else begin
                  state  <= DRIVE;
                  cnt    <= CNT_LOAD;
                  cfgdat <= cfg_word(SEL_NONE, dst_q);
                  if (LAST_ON_ENTRY) done <= grant_vec(w);
               end
            end
            DRIVE: begin
               if (cnt == '0) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else begin
                  cnt    <= cnt - 1'b1;
                  cfgdat <= cfg_word(SEL_NONE, dst_q);
                  if (cnt == CW'(1)) done <= grant_vec(w);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_act_sched.sv
// Randomized bench for act_sched: two instances (HOLD=1, HOLD=5) against a pass-level reference model.
module tb_act_sched;

`ifdef ACT_SCHED_TURN_EN
   localparam int TURN = 1;
`else
   localparam int TURN = 0;
`endif

   typedef struct packed {
      logic [1:0] gnt;
      logic [1:0] done;
      logic       busy;
      logic [3:0] cfg;
      logic       rtm;
   } obs_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   logic [1:0] req   [2];
   logic [1:0] src   [2];
   logic [3:0] dst   [2];
   logic [1:0] gnt_o [2];
   logic [1:0] done_o[2];
   logic       busy_o[2];
   logic [3:0] cfg_o [2];
   logic       rtm_o [2];

   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;

   obs_t sched   [2][0:19];
   int   slen    [2];
   int   spos    [2];
   logic mp      [2];
   obs_t exp_cur [2];
   obs_t exp_prev[2];
   int   mode    [2];   // 0 random, 1 hold request high, 2 directed

   always #5 clk = ~clk;

   act_sched #(.HOLD(1), .CW(4)) u_h1 (
      .clk(clk), .rst(rst), .req(req[0]), .src(src[0]), .dst(dst[0]),
      .gnt(gnt_o[0]), .done(done_o[0]), .busy(busy_o[0]), .cfgdat(cfg_o[0]), .rtm_en(rtm_o[0])
   );

   act_sched #(.HOLD(5), .CW(4)) u_h5 (
      .clk(clk), .rst(rst), .req(req[1]), .src(src[1]), .dst(dst[1]),
      .gnt(gnt_o[1]), .done(done_o[1]), .busy(busy_o[1]), .cfgdat(cfg_o[1]), .rtm_en(rtm_o[1])
   );

   function automatic int hold_of(input int k);
      return (k == 0) ? 1 : 5;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // A whole pass is laid out as a list of per-cycle output words when it is granted.
   task automatic build(input int k);
      logic       w;
      logic [1:0] d;
      logic [1:0] oh;
      obs_t       e;
      int         n;
      w  = (req[k] == 2'b11) ? mp[k] : req[k][1];
      mp[k] = ~w;
      d  = w ? dst[k][3:2] : dst[k][1:0];
      oh = w ? 2'b10 : 2'b01;
      n  = 0;
      e = '0;
      e.gnt  = oh;
      e.busy = 1'b1;
      e.rtm  = 1'b1;
      e.cfg  = {2'b00, 1'b1, src[k][w]};
      if (TURN == 0 && d == 2'b00) e.done = oh;
      sched[k][n] = e; n++;
      if (TURN == 1) begin
         e = '0;
         e.busy = 1'b1;
         if (d == 2'b00) e.done = oh;
         sched[k][n] = e; n++;
      end
      if (d != 2'b00) begin
         for (int j = 0; j < hold_of(k); j++) begin
            e = '0;
            e.busy = 1'b1;
            e.cfg  = {d, 2'b00};
            if (j == hold_of(k) - 1) e.done = oh;
            sched[k][n] = e; n++;
         end
      end
      slen[k] = n;
      spos[k] = 0;
   endtask

   task automatic model_edge();
      for (int k = 0; k < 2; k++) begin
         exp_prev[k] = exp_cur[k];
         if (!rst) begin
            slen[k] = 0;
            spos[k] = 0;
            mp[k]   = 1'b0;
            exp_cur[k] = '0;
         end else begin
            if (spos[k] >= slen[k] && !exp_prev[k].busy && (|req[k])) build(k);
            if (spos[k] < slen[k]) begin
               exp_cur[k] = sched[k][spos[k]];
               spos[k]++;
            end else begin
               exp_cur[k] = '0;
            end
         end
      end
   endtask

   task automatic req_update();
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < 2; i++) begin
            if (mode[k] != 1 && exp_prev[k].gnt[i]) req[k][i] = 1'b0;
            if (mode[k] == 0 && !req[k][i] && $urandom_range(0, 3) == 0) begin
               req[k][i] = 1'b1;
               src[k][i] = 1'($urandom_range(0, 1));
               if (i == 0) dst[k][1:0] = 2'($urandom_range(0, 3));
               else        dst[k][3:2] = 2'($urandom_range(0, 3));
            end
         end
      end
   endtask

   task automatic check_all();
      string h;
      for (int k = 0; k < 2; k++) begin
         h = $sformatf("h%0d", hold_of(k));
         check({h, "_gnt"},  32'(gnt_o[k]),  32'(exp_cur[k].gnt));
         check({h, "_done"}, 32'(done_o[k]), 32'(exp_cur[k].done));
         check({h, "_busy"}, 32'(busy_o[k]), 32'(exp_cur[k].busy));
         check({h, "_cfg"},  32'(cfg_o[k]),  32'(exp_cur[k].cfg));
         check({h, "_rtm"},  32'(rtm_o[k]),  32'(exp_cur[k].rtm));
         check({h, "_excl"}, 32'((|cfg_o[k][1:0]) && (|cfg_o[k][3:2])), 32'(0));
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      cyc++;
      model_edge();
      #1;
      req_update();
      @(negedge clk);
      check_all();
   endtask

   task automatic check_zero(input string tag);
      for (int k = 0; k < 2; k++) begin
         check($sformatf("%s_h%0d", tag, hold_of(k)),
               32'({gnt_o[k], done_o[k], busy_o[k], cfg_o[k], rtm_o[k]}), 32'(0));
      end
   endtask

   logic [1:0] gseq [3];
   logic [1:0] gsel [3];
   int         gcyc [3];
   int         ng;
   int         waited;

   initial begin
      for (int k = 0; k < 2; k++) begin
         req[k] = 2'b00; src[k] = 2'b00; dst[k] = 4'b0000;
         slen[k] = 0; spos[k] = 0; mp[k] = 1'b0;
         exp_cur[k] = '0; exp_prev[k] = '0; mode[k] = 2;
      end
      #1 rst = 1'b0;
      #2 check_zero("reset_async");
      repeat (3) cycle();

      // Contention on the HOLD=5 unit, single directed pass on the HOLD=1 unit.
      rst = 1'b1;
      mode[1] = 1;
      req[1] = 2'b11; src[1] = 2'b10; dst[1] = 4'b0110;
      req[0] = 2'b01; src[0] = 2'b01; dst[0] = 4'b0010;
      ng = 0;
      for (int c = 0; c < 60 && ng < 3; c++) begin
         cycle();
         if (gnt_o[1] != 2'b00) begin
            gseq[ng] = gnt_o[1];
            gsel[ng] = cfg_o[1][1:0];
            gcyc[ng] = cyc;
            ng++;
         end
      end
      check("contention_grants", 32'(ng), 32'(3));
      if (ng == 3) begin
         check("cont_g0", 32'(gseq[0]), 32'(2'b01));
         check("cont_g1", 32'(gseq[1]), 32'(2'b10));
         check("cont_g2", 32'(gseq[2]), 32'(2'b01));
         check("cont_sel0", 32'(gsel[0]), 32'(2'b10));
         check("cont_sel1", 32'(gsel[1]), 32'(2'b11));
         check("cont_sel2", 32'(gsel[2]), 32'(2'b10));
         check("cont_gap01", 32'(gcyc[1] - gcyc[0]), 32'(5 + 2 + TURN));
         check("cont_gap12", 32'(gcyc[2] - gcyc[1]), 32'(5 + 2 + TURN));
      end

      mode[0] = 0;
      mode[1] = 0;
      repeat (400) cycle();

      // Drain both units, then abandon a HOLD=5 pass in its second DRIVE cycle.
      mode[0] = 2; mode[1] = 2;
      req[0] = 2'b00; req[1] = 2'b00;
      waited = 0;
      while (waited < 30 && (busy_o[0] || busy_o[1] || exp_cur[0].busy || exp_cur[1].busy)) begin
         cycle();
         waited++;
      end
      check("drain_idle", 32'(waited < 30), 32'(1));
      cycle();
      req[1] = 2'b01; src[1] = 2'b00; dst[1] = 4'b0011;
      repeat (3 + TURN) cycle();
      check("rst_pre_drive", 32'(cfg_o[1]), 32'(4'b1100));
      req[1] = 2'b10; src[1] = 2'b00; dst[1] = 4'b0100;
      #2 rst = 1'b0;
      #1 check_zero("rst_mid_pass");
      repeat (2) cycle();
      @(negedge clk);
      rst = 1'b1;
      cycle();
      check("rst_first_grant", 32'(gnt_o[1]), 32'(2'b10));
      repeat (10) cycle();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
